// File: rtl/mdr_param_unit_pkg.sv
// Shared MDR datapath types: operation select, ALU control and sequencer states.
package mdr_param_unit_pkg;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2,
    NON  = 2'd3
  } op_select_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    SUBS = 2'd1,
    ADD  = 2'd2,
    NULL = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mdr_state_t;

  // Iterations spent in CALC: one per operand bit, or one per root digit pair.
  function automatic int iter_count(op_select_t op, int dw);
    return (op == ROOT) ? dw / 2 : dw;
  endfunction

endpackage

// File: rtl/mdr_addsub_alu.sv
// Combinational add/subtract stage shared by the multiply, divide and root iterations.
module mdr_addsub_alu
  import mdr_param_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  alu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      ZERO:    y = '0;
      SUBS:    y = a - b;
      ADD:     y = a + b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mdr_param_unit.sv
// Sequential multiply / divide / square-root unit iterating over one shared 2*DW add/subtract ALU.
module mdr_param_unit
  import mdr_param_unit_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  op_select_t      op_i,
  input  logic            signed_i,
  input  logic [DW-1:0]   data_x_i,
  input  logic [DW-1:0]   data_y_i,
  output logic [2*DW-1:0] result_o,
  output logic [DW-1:0]   remainder_o,
  output logic            busy_o,
  output logic            ready_o,
  output logic            error_o
);

  localparam int WW = 2 * DW;
  localparam int CW = $clog2(DW) + 1;

  typedef logic [WW-1:0] wide_t;
  typedef logic [CW-1:0] cnt_t;

  mdr_state_t state, next_state;

  op_select_t    op_r;
  logic          signed_r;
  logic [DW-1:0] sh_r;
  logic [DW-1:0] opnd_r;
  logic [DW-1:0] root_r;
  wide_t         acc_r;
  cnt_t          cnt_r;
  logic          neg_res_r;
  logic          neg_rem_r;
  logic          err_r;

  cnt_t          cnt_last;
  logic          accept;
  logic          last_iter;
  logic          load_err;
  logic [DW-1:0] mag_x;
  logic [DW-1:0] mag_y;

  alu_op_t       alu_op;
  wide_t         alu_a;
  wide_t         alu_b;
  wide_t         alu_y;

  mdr_addsub_alu #(
    .W(WW)
  ) u_alu (
    .op(alu_op),
    .a (alu_a),
    .b (alu_b),
    .y (alu_y)
  );

  assign cnt_last = cnt_t'(iter_count(op_r, DW) - 1);
  assign mag_x    = (signed_r && sh_r[DW-1])   ? -sh_r   : sh_r;
  assign mag_y    = (signed_r && opnd_r[DW-1]) ? -opnd_r : opnd_r;

  always_comb begin
    load_err = 1'b0;
    case (op_r)
      DIV:     load_err = (opnd_r == '0);
      ROOT:    load_err = signed_r && sh_r[DW-1];
      NON:     load_err = 1'b1;
      default: load_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = (cnt_r == cnt_last);
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD:    next_state = load_err ? DONE : CALC;
      CALC:    next_state = last_iter ? DONE : CALC;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ALU steering. In CALC it performs one algorithm step; in DONE it applies the
  // sign fix (0 - magnitude) or the final non-restoring root remainder correction.
  always_comb begin
    alu_op = ZERO;
    alu_a  = '0;
    alu_b  = '0;
    case (state)
      CALC: begin
        case (op_r)
          MULT: begin
            alu_a  = acc_r << 1;
            alu_b  = {{DW{1'b0}}, opnd_r};
            alu_op = sh_r[DW-1] ? ADD : NULL;
          end
          DIV: begin
            alu_a  = {acc_r[WW-2:0], sh_r[DW-1]};
            alu_b  = {{DW{1'b0}}, opnd_r};
            alu_op = SUBS;
          end
          ROOT: begin
            // Partial remainder negative: add (Q<<2)|3, otherwise subtract (Q<<2)|1.
            alu_a  = {acc_r[WW-3:0], sh_r[DW-1:DW-2]};
            alu_b  = {{(DW-2){1'b0}}, root_r, acc_r[WW-1], 1'b1};
            alu_op = acc_r[WW-1] ? ADD : SUBS;
          end
          default: alu_op = ZERO;
        endcase
      end
      DONE: begin
        case (op_r)
          MULT: begin
            alu_a  = neg_res_r ? '0 : acc_r;
            alu_b  = acc_r;
            alu_op = neg_res_r ? SUBS : NULL;
          end
          DIV: begin
            alu_a  = neg_res_r ? '0 : {{DW{1'b0}}, sh_r};
            alu_b  = {{DW{1'b0}}, sh_r};
            alu_op = neg_res_r ? SUBS : NULL;
          end
          ROOT: begin
            alu_a  = acc_r;
            alu_b  = {{(DW-1){1'b0}}, root_r, 1'b1};
            alu_op = acc_r[WW-1] ? ADD : NULL;
          end
          default: alu_op = ZERO;
        endcase
      end
      default: alu_op = ZERO;
    endcase
  end

  // sh_r carries the multiplier, the dividend (turning into the quotient) or the radicand.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= MULT;
      signed_r    <= 1'b0;
      sh_r        <= '0;
      opnd_r      <= '0;
      root_r      <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      err_r       <= 1'b0;
      result_o    <= '0;
      remainder_o <= '0;
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r     <= op_i;
            signed_r <= signed_i;
            sh_r     <= data_x_i;
            opnd_r   <= data_y_i;
            busy_o   <= 1'b1;
            error_o  <= 1'b0;
          end
        end
        LOAD: begin
          sh_r      <= mag_x;
          opnd_r    <= mag_y;
          acc_r     <= '0;
          root_r    <= '0;
          cnt_r     <= '0;
          err_r     <= load_err;
          neg_res_r <= signed_r && (sh_r[DW-1] ^ opnd_r[DW-1]);
          neg_rem_r <= signed_r && sh_r[DW-1];
        end
        CALC: begin
          cnt_r <= cnt_r + cnt_t'(1);
          case (op_r)
            MULT: begin
              acc_r <= alu_y;
              sh_r  <= sh_r << 1;
            end
            DIV: begin
              acc_r <= alu_y[WW-1] ? alu_a : alu_y;
              sh_r  <= {sh_r[DW-2:0], ~alu_y[WW-1]};
            end
            ROOT: begin
              acc_r  <= alu_y;
              sh_r   <= sh_r << 2;
              root_r <= {root_r[DW-2:0], ~alu_y[WW-1]};
            end
            default: acc_r <= acc_r;
          endcase
        end
        DONE: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          error_o <= err_r;
          if (err_r) begin
            result_o    <= '0;
            remainder_o <= '0;
          end else begin
            case (op_r)
              MULT: begin
                result_o    <= alu_y;
                remainder_o <= '0;
              end
              DIV: begin
                result_o    <= alu_y;
                remainder_o <= neg_rem_r ? -acc_r[DW-1:0] : acc_r[DW-1:0];
              end
              ROOT: begin
                result_o    <= {{DW{1'b0}}, root_r};
                remainder_o <= alu_y[DW-1:0];
              end
              default: begin
                result_o    <= '0;
                remainder_o <= '0;
              end
            endcase
          end
        end
        default: ready_o <= 1'b0;
      endcase
    end
  end

endmodule
